// File: rtl/deco_arb_pkg.sv
// deco_arb_pkg: shared types, constants and PC legality helper for the fetch arbiter
package deco_arb_pkg;
  localparam int NUM_PORTS = 2;
  typedef logic port_t;
  typedef struct packed {
    logic  valid;
    port_t port;
    logic  err;
  } tag_t;
  // A PC is legal when word aligned and inside the program image.
  function automatic logic pc_legal(input logic [63:0] pc, input int unsigned prog_words);
    return (pc[1:0] == 2'b00) && ((pc >> 2) < 64'(prog_words));
  endfunction
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-input round-robin grant, favouring the port that did not win last
module rr_arb2
  import deco_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  port_t      last_gnt_i,
  input  logic       halt_i,
  output logic [1:0] gnt_o
);
  // Under contention the port other than last_gnt wins; a lone requester always wins.
  always_comb begin
    gnt_o = halt_i ? 2'b00 : (req_i == 2'b11) ? (last_gnt_i ? 2'b01 : 2'b10) : req_i;
  end
endmodule

// File: rtl/deco_fetch_arbiter.sv
// deco_fetch_arbiter: shares one decompressor between two fetch ports with tagged in-order responses
module deco_fetch_arbiter
  import deco_arb_pkg::*;
#(
  parameter int          ADDR_W     = 32,
  parameter int          INSTR_W    = 32,
  parameter int unsigned PROG_WORDS = 112,
  parameter int          DECO_LAT   = 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               halt,
  input  logic [NUM_PORTS-1:0]               req_valid,
  input  logic [NUM_PORTS-1:0][ADDR_W-1:0]   req_pc,
  output logic [NUM_PORTS-1:0]               req_ready,
  output logic [NUM_PORTS-1:0]               resp_valid,
  output logic [NUM_PORTS-1:0][INSTR_W-1:0]  resp_instr,
  output logic [NUM_PORTS-1:0]               resp_err,
  output logic [ADDR_W-1:0]                  deco_pc,
  input  logic [INSTR_W-1:0]                 deco_instr
);
  localparam int STAGES = DECO_LAT + 1;
  logic [NUM_PORTS-1:0] gnt;
  logic acc;
  port_t sel;
  logic legal;
  logic [ADDR_W-1:0] pc_sel;
  tag_t tag_d, tail;
  tag_t tag_q [STAGES];
  port_t last_gnt_q, last_gnt_d;
  logic [ADDR_W-1:0] deco_pc_q, deco_pc_d;
  logic [NUM_PORTS-1:0] resp_valid_q, resp_valid_d, resp_err_q, resp_err_d;
  logic [NUM_PORTS-1:0][INSTR_W-1:0] resp_instr_q, resp_instr_d;
  // Reset is folded into halt so nothing is offered while the block is held in reset.
  rr_arb2 u_arb (
    .req_i      (req_valid),
    .last_gnt_i (last_gnt_q),
    .halt_i     (halt | reset),
    .gnt_o      (gnt)
  );
  assign req_ready  = gnt;
  assign acc        = |gnt;
  assign sel        = gnt[1];
  assign tail       = tag_q[STAGES-1];
  assign deco_pc    = deco_pc_q;
  assign resp_valid = resp_valid_q;
  assign resp_instr = resp_instr_q;
  assign resp_err   = resp_err_q;
  // Accept side: tag the winner, move the RR pointer, load deco_pc only for legal PCs.
  always_comb begin
    pc_sel     = req_pc[sel];
    legal      = pc_legal(64'(pc_sel), PROG_WORDS);
    tag_d      = '{valid: acc, port: sel, err: !legal};
    last_gnt_d = acc ? sel : last_gnt_q;
    deco_pc_d  = (acc && legal) ? pc_sel : deco_pc_q;
  end
  // Response side: steer the tail entry to its port; illegal entries return a zero word.
  always_comb begin
    resp_valid_d = '0;
    resp_err_d   = '0;
    resp_instr_d = '0;
    if (tail.valid) begin
      resp_valid_d[tail.port] = 1'b1;
      resp_err_d[tail.port]   = tail.err;
      resp_instr_d[tail.port] = tail.err ? '0 : deco_instr;
    end
  end
  // State update: stall-free tag shift register plus pointer, PC and response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_gnt_q   <= 1'b1;
      deco_pc_q    <= '0;
      resp_valid_q <= '0;
      resp_err_q   <= '0;
      resp_instr_q <= '0;
      for (int i = 0; i < STAGES; i++) tag_q[i] <= '0;
    end else begin
      last_gnt_q   <= last_gnt_d;
      deco_pc_q    <= deco_pc_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_instr_q <= resp_instr_d;
      tag_q[0]     <= tag_d;
      for (int i = 1; i < STAGES; i++) tag_q[i] <= tag_q[i-1];
    end
  end
endmodule

// File: tb/tb_deco_fetch_arbiter.sv
// tb_deco_fetch_arbiter: directed and randomized checks against a queue-based reference model
module tb_deco_fetch_arbiter;
  localparam int PROG_WORDS = 112;
  logic clk, reset, halt;
  logic [1:0] req_valid, req_ready, resp_valid, resp_err;
  logic [1:0][31:0] req_pc, resp_instr;
  logic [31:0] deco_pc, deco_instr;
  typedef struct {
    int          due;
    logic        p;
    logic        err;
    logic [31:0] ins;
  } exp_t;
  exp_t q[$];
  int checks = 0, passes = 0, cyc = 0;
  logic last_m;
  logic [31:0] dpc_m;

  deco_fetch_arbiter dut (
    .clk(clk), .reset(reset), .halt(halt),
    .req_valid(req_valid), .req_pc(req_pc), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_instr(resp_instr), .resp_err(resp_err),
    .deco_pc(deco_pc), .deco_instr(deco_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in program image; word 111 carries the known last instruction.
  function automatic logic [31:0] rom_word(input logic [31:0] pc);
    logic [29:0] w;
    w = pc[31:2];
    return (w == 30'd111) ? 32'h1EFF2FE1 : ((32'(w) * 32'h9E3779B1) ^ 32'hA5A50F0F);
  endfunction

  // Registered decompressor model with one cycle of latency.
  always @(posedge clk) deco_instr <= rom_word(deco_pc);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes = passes + 1;
    else $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
  endtask

  task automatic step(input logic rst, input logic hlt, input logic [1:0] v,
                      input logic [31:0] p0, input logic [31:0] p1);
    logic [1:0] g, ev, ee;
    logic [1:0][31:0] ei;
    logic port, err;
    logic [31:0] pc;
    exp_t e;
    reset = rst; halt = hlt; req_valid = v; req_pc[0] = p0; req_pc[1] = p1;
    if (rst || hlt || v == 2'b00) g = 2'b00;
    else if (v == 2'b11) g = last_m ? 2'b01 : 2'b10;
    else g = v;
    #1 chk("req_ready", 64'(req_ready), 64'(g));
    @(posedge clk);
    cyc++;
    if (rst) begin
      q.delete();
      last_m = 1'b1;
      dpc_m = '0;
    end else if (g != 2'b00) begin
      port = g[1];
      pc = port ? p1 : p0;
      err = (pc[1:0] != 2'b00) || (pc[31:2] >= 30'(PROG_WORDS));
      q.push_back('{cyc + 2, port, err, err ? 32'h0 : rom_word(pc)});
      last_m = port;
      if (!err) dpc_m = pc;
    end
    #1;
    ev = '0; ee = '0; ei = '0;
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      ev[e.p] = 1'b1;
      ee[e.p] = e.err;
      ei[e.p] = e.ins;
    end
    chk("resp_valid", 64'(resp_valid), 64'(ev));
    chk("resp_err", 64'(resp_err), 64'(ee));
    chk("resp_instr", 64'(resp_instr), 64'(ei));
    chk("deco_pc", 64'(deco_pc), 64'(dpc_m));
  endtask

  initial begin
    logic [31:0] rp [2];
    last_m = 1'b1;
    dpc_m = '0;
    reset = 1'b1; halt = 1'b0; req_valid = '0; req_pc = '0;
    // reset state, with requests presented to confirm req_ready stays low
    for (int i = 0; i < 3; i++) step(1, 0, 2'b11, 32'h0, 32'h4);
    // single port sweep over the whole image, then drain
    for (int i = 0; i < PROG_WORDS; i++) step(0, 0, 2'b01, 32'(i * 4), 32'h0);
    for (int i = 0; i < 3; i++) step(0, 0, 2'b00, 32'h0, 32'h0);
    // contention straight after reset: port 0 first, then alternate
    step(1, 0, 2'b00, 32'h0, 32'h0);
    for (int i = 0; i < 8; i++) step(0, 0, 2'b11, 32'h0, 32'h4);
    for (int i = 0; i < 3; i++) step(0, 0, 2'b00, 32'h0, 32'h0);
    // illegal PCs on port 1 around legal boundary accesses
    step(0, 0, 2'b10, 32'h0, 32'h1BC);
    step(0, 0, 2'b10, 32'h0, 32'h1C0);
    step(0, 0, 2'b10, 32'h0, 32'h002);
    for (int i = 0; i < 3; i++) step(0, 0, 2'b00, 32'h0, 32'h0);
    // halt with two entries in flight, then resume
    step(0, 0, 2'b11, 32'h8, 32'hC);
    step(0, 0, 2'b11, 32'h8, 32'hC);
    for (int i = 0; i < 3; i++) step(0, 1, 2'b11, 32'h10, 32'h14);
    for (int i = 0; i < 4; i++) step(0, 0, 2'b11, 32'h10, 32'h14);
    for (int i = 0; i < 3; i++) step(0, 0, 2'b00, 32'h0, 32'h0);
    // reset with an entry in flight, then contention
    step(0, 0, 2'b01, 32'h10, 32'h0);
    step(1, 0, 2'b00, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) step(0, 0, 2'b00, 32'h0, 32'h0);
    for (int i = 0; i < 4; i++) step(0, 0, 2'b11, 32'h20, 32'h24);
    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < 2; k++) begin
        case ($urandom_range(0, 9))
          7:       rp[k] = {23'($urandom_range(0, 127)), 7'($urandom_range(0, 127)), 2'($urandom_range(1, 3))};
          8:       rp[k] = 32'h1C0 + 32'($urandom_range(0, 63)) * 4;
          9:       rp[k] = $urandom;
          default: rp[k] = 32'($urandom_range(0, PROG_WORDS - 1)) * 4;
        endcase
      end
      step($urandom_range(0, 49) == 0, $urandom_range(0, 9) == 0,
           2'($urandom_range(0, 3)), rp[0], rp[1]);
    end
    for (int i = 0; i < 3; i++) step(0, 0, 2'b00, 32'h0, 32'h0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/deco_fetch_arbiter.md
# deco_fetch_arbiter

Round-robin fetch arbiter that shares one instruction decompressor (`topReg`) between two CPU fetch ports. Each cycle it accepts at most one word-aligned PC request, drives the decompressor PC, and tracks the request through the decompressor's fixed latency. It returns the decompressed instruction to the originating port. The block sits between the CPU fetch stages and `topReg`; `topReg` itself is unchanged.

## Interface
- `ADDR_W`, 32, PC width
- `INSTR_W`, 32, instruction width
- `PROG_WORDS`, 112, number of valid instruction words; the last legal PC is `(PROG_WORDS-1)*4` = 0x1BC
- `DECO_LAT`, 1, cycles from a `deco_pc` update to a valid `deco_instr` (`topReg` register variant = 1)

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock
- `reset`  in  1  synchronous active-high reset
- `halt`  in  1  when high, no new requests are accepted
- `req_valid`  in  2  per-port request valid
- `req_pc`  in  2×ADDR_W  per-port requested PC
- `req_ready`  out  2  per-port accept; at most one bit high
- `resp_valid`  out  2  per-port one-cycle response pulse
- `resp_instr`  out  2×INSTR_W  per-port decompressed instruction
- `resp_err`  out  2  per-port error: misaligned or out-of-range PC
- `deco_pc`  out  ADDR_W  to `topReg` PCcpu
- `deco_instr`  in  INSTR_W  from `topReg` DecompressInstr

## Operation
- **Arbitration:** `req_ready` is combinational from `req_valid`, `halt` and the RR pointer `last_gnt`.
  - With a single requester, that port wins.
  - With both requesting, the port not equal to `last_gnt` wins.
  - `halt` high forces `req_ready` = 0.
- **Accept:** a transfer occurs on the edge where `req_valid[i] & req_ready[i]`. `last_gnt` is then set to `i`.
- **Legality check at accept:**
  - `err` = `pc[1:0]` != 0, or `pc[ADDR_W-1:2]` >= `PROG_WORDS`.
  - Legal: `deco_pc` is loaded with `pc`.
  - Illegal: `deco_pc` holds its previous value. The entry still occupies a pipeline slot.
- **Tag pipeline:** `DECO_LAT+1` stages, each holding `{valid, port, err}`. It shifts every cycle with no stalls and sustains one accept per cycle.
- **Response:** when the tail stage is valid, `resp_valid[port]` pulses for one cycle.
  - `resp_instr[port]` = `deco_instr` sampled on that edge, or 0 if `err`.
  - `resp_err[port]` = `err`.
  - Non-targeted port outputs hold 0.
- **No response backpressure:** requesters must always accept responses.
- **Ordering:** responses leave in accept order. Per port, responses are in request order.

## Timing
- **Reset values:** `req_ready` 0 during reset; `resp_valid` 0; `resp_instr` 0; `resp_err` 0; `deco_pc` 0; `last_gnt` 1, so port 0 has priority first; all tag stages invalid.
- **Latency:** accept on edge E → `deco_pc` updated at E → `deco_instr` valid after E+`DECO_LAT` → captured at E+`DECO_LAT`+1. `resp_valid` is high in the cycle after that edge. With `DECO_LAT`=1, the response is valid two edges after accept.
- **Throughput:** back-to-back accepts from alternating ports give one response per cycle.
- **Dropped valid:** `req_valid` deasserted before acceptance is legal and produces no response.
- **Simultaneous events:**
  - Accept and tail response on the same edge are independent.
  - `halt` asserted mid-stream does not stop in-flight entries; they drain normally.
- **Reset mid-operation:** all in-flight entries are discarded and no responses are emitted. `last_gnt` returns to 1.
- **PC range boundary:** 0x1BC is legal; 0x1C0 is out of range (`err`). PC wrap-around beyond `ADDR_W` is not special-cased; the range check covers it.

## Structure
- Package `deco_arb_pkg`:
  - `NUM_PORTS` = 2
  - typedef `port_t` (1 bit)
  - struct `tag_t {logic valid; port_t port; logic err;}`
  - function `pc_legal(pc, prog_words)`
- Sub-module `rr_arb2`: combinational two-input round-robin grant from `{req, last_gnt, halt}`, outputting a one-hot grant.
- Top level: accept logic, `deco_pc` register, `last_gnt` register, tag shift register, response demux.

## Test plan
- **Single port sweep:** port 0 requests PC 0x000–0x1BC one per cycle → 112 responses, each two cycles after accept, matching the golden file; the PC 0x1BC response = 0x1EFF2FE1.
- **Contention:** both ports valid continuously, port 0 PC 0x000, port 1 PC 0x004 → grants alternate 0,1,0,1 starting with port 0 after reset; each port receives its own instruction.
- **Illegal PCs:** port 1 requests 0x1C0, then 0x002 → `resp_err[1]`=1 and `resp_instr[1]`=0 for both, and `deco_pc` unchanged across those accepts.
- **Halt:** `halt` raised with two entries in flight → `req_ready`=0 immediately; both in-flight responses still arrive; releasing `halt` resumes with the RR pointer intact.
- **Reset mid-flight:** accept PC 0x010, assert `reset` on the next edge → no `resp_valid` ever appears for it; outputs read 0; port 0 wins the first post-reset contention.
